// File: rtl/out_reg_arbiter_if.sv
// Bundle of requester-side and OUT_* register-port signals for out_reg_arbiter.
// master = requesters plus downstream register block, slave = the arbiter.
interface out_reg_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_stb;
    logic [N_REQ-1:0]        req_busy;
    logic [ADDR_W-1:0]       out_reg_addr;
    logic [DATA_W-1:0]       out_reg_data;
    logic                    out_reg_stb;
    logic                    out_reg_busy;
    logic [GW-1:0]           grant_id;
    logic [N_REQ-1:0]        overflow;
    logic [N_REQ-1:0]        overflow_clr;

    modport master (
        output req_addr,
        output req_data,
        output req_stb,
        input  req_busy,
        input  out_reg_addr,
        input  out_reg_data,
        input  out_reg_stb,
        output out_reg_busy,
        input  grant_id,
        input  overflow,
        output overflow_clr
    );

    modport slave (
        input  req_addr,
        input  req_data,
        input  req_stb,
        output req_busy,
        output out_reg_addr,
        output out_reg_data,
        output out_reg_stb,
        input  out_reg_busy,
        output grant_id,
        output overflow,
        input  overflow_clr
    );
endinterface

// File: rtl/out_reg_arbiter.sv
// Round-robin arbiter sharing the OUT_* register write port between N_REQ
// requesters, each with a one-deep capture slot and a sticky overflow flag.
module out_reg_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input logic              clk,
    input logic              rst,
    out_reg_arbiter_if.slave bus
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STB,
        S_GAP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [N_REQ-1:0]  full_q;
    logic [ADDR_W-1:0] slot_addr_q [N_REQ];
    logic [DATA_W-1:0] slot_data_q [N_REQ];
    logic [N_REQ-1:0]  ovf_q;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              stb_q;
    logic [GW-1:0]     grant_q;

    logic              win_any;
    logic [GW-1:0]     win_id;
    logic              issue;
    int                cand;

    // Round-robin search: first full slot after the last issued requester.
    always_comb begin
        win_any = 1'b0;
        win_id  = grant_q;
        cand    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(grant_q) + k) % N_REQ;
            if (!win_any && full_q[cand]) begin
                win_any = 1'b1;
                win_id  = GW'(cand);
            end
        end
    end

    // Issue FSM next-state: grant only from idle when downstream is free.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!bus.out_reg_busy && win_any) begin
                    issue   = 1'b1;
                    state_d = S_STB;
                end
            end
            S_STB: begin
                state_d = S_GAP;
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture slots: a strobe into an occupied slot (even one being granted
    // this edge) is dropped and flagged; set beats clear on overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= '0;
            ovf_q  <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                slot_addr_q[i] <= '0;
                slot_data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.req_stb[i] && !full_q[i]) begin
                    full_q[i]      <= 1'b1;
                    slot_addr_q[i] <= bus.req_addr[i*ADDR_W +: ADDR_W];
                    slot_data_q[i] <= bus.req_data[i*DATA_W +: DATA_W];
                end else if (issue && (win_id == GW'(i))) begin
                    full_q[i] <= 1'b0;
                end

                if (bus.req_stb[i] && full_q[i]) begin
                    ovf_q[i] <= 1'b1;
                end else if (bus.overflow_clr[i]) begin
                    ovf_q[i] <= 1'b0;
                end
            end
        end
    end

    // Downstream output registers; addr/data hold between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            data_q  <= '0;
            stb_q   <= 1'b0;
            grant_q <= GW'(N_REQ - 1);
        end else begin
            stb_q <= issue;
            if (issue) begin
                addr_q  <= slot_addr_q[win_id];
                data_q  <= slot_data_q[win_id];
                grant_q <= win_id;
            end
        end
    end

    assign bus.req_busy     = full_q;
    assign bus.overflow     = ovf_q;
    assign bus.out_reg_addr = addr_q;
    assign bus.out_reg_data = data_q;
    assign bus.out_reg_stb  = stb_q;
    assign bus.grant_id     = grant_q;

endmodule

// File: tb/tb_out_reg_arbiter.sv
// Self-checking bench for out_reg_arbiter: directed scenarios plus random
// traffic, compared each cycle against a behavioural slot/cooldown model.
module tb_out_reg_arbiter;
    localparam int N  = 2;
    localparam int AW = 6;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    out_reg_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    out_reg_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: slot contents, cycles left before the arbiter may
    // issue again, last issued requester, and expected output registers.
    bit            m_v   [N];
    logic [AW-1:0] m_a   [N];
    logic [DW-1:0] m_d   [N];
    bit            m_ovf [N];
    int            m_cool;
    int            m_last;
    bit            m_stb;
    logic [AW-1:0] m_ea;
    logic [DW-1:0] m_ed;

    int obs[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i]   = 0;
            m_a[i]   = '0;
            m_d[i]   = '0;
            m_ovf[i] = 0;
        end
        m_cool = 0;
        m_last = N - 1;
        m_stb  = 0;
        m_ea   = '0;
        m_ed   = '0;
    endtask

    task automatic model_edge();
        int win;
        int c;
        win = -1;
        if (m_cool == 0) begin
            if (!bus.out_reg_busy) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (win < 0 && m_v[c]) win = c;
                end
            end
        end else begin
            m_cool--;
        end
        for (int i = 0; i < N; i++) begin
            if (bus.req_stb[i] && m_v[i]) m_ovf[i] = 1;
            else if (bus.overflow_clr[i]) m_ovf[i] = 0;
            if (bus.req_stb[i] && !m_v[i]) begin
                m_v[i] = 1;
                m_a[i] = bus.req_addr[i*AW +: AW];
                m_d[i] = bus.req_data[i*DW +: DW];
            end
        end
        m_stb = (win >= 0);
        if (win >= 0) begin
            m_ea      = m_a[win];
            m_ed      = m_d[win];
            m_v[win]  = 0;
            m_last    = win;
            m_cool    = 2;
        end
    endtask

    task automatic check_all();
        logic [N-1:0] v;
        logic [N-1:0] o;
        for (int i = 0; i < N; i++) begin
            v[i] = m_v[i];
            o[i] = m_ovf[i];
        end
        check("req_busy", 64'(bus.req_busy), 64'(v));
        check("overflow", 64'(bus.overflow), 64'(o));
        check("out_stb", 64'(bus.out_reg_stb), 64'(m_stb));
        check("out_addr", 64'(bus.out_reg_addr), 64'(m_ea));
        check("out_data", 64'(bus.out_reg_data), 64'(m_ed));
        check("grant_id", 64'(bus.grant_id), 64'(m_last));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        if (bus.out_reg_stb) obs.push_back(int'(bus.grant_id));
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        bus.req_stb[i]          = 1'b1;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic clear_inputs();
        bus.req_stb      = '0;
        bus.overflow_clr = '0;
        bus.out_reg_busy = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        #3;
        model_reset();
        check("rst_stb", 64'(bus.out_reg_stb), 64'd0);
        check("rst_gid", 64'(bus.grant_id), 64'(N - 1));
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.req_addr     = '0;
        bus.req_data     = '0;
        clear_inputs();
        model_reset();
        #23;
        check("por_addr", 64'(bus.out_reg_addr), 64'd0);
        check("por_busy", 64'(bus.req_busy), 64'd0);
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Single write: strobe one cycle after the capture edge.
        set_req(0, 6'd5, 32'hDEADBEEF);
        step();
        bus.req_stb = '0;
        check("single_busy0", 64'(bus.req_busy[0]), 64'd1);
        step();
        check("single_stb", 64'(bus.out_reg_stb), 64'd1);
        check("single_addr", 64'(bus.out_reg_addr), 64'd5);
        check("single_data", 64'(bus.out_reg_data), 64'hDEADBEEF);
        check("single_gid", 64'(bus.grant_id), 64'd0);
        check("single_busy0b", 64'(bus.req_busy[0]), 64'd0);
        for (int n = 0; n < 3; n++) step();

        // Contention from reset: 0 then 1, twice.
        do_reset();
        obs.delete();
        for (int r = 0; r < 2; r++) begin
            set_req(0, 6'(r + 1), 32'hA000_0000 + 32'(r));
            set_req(1, 6'(r + 9), 32'hB000_0000 + 32'(r));
            step();
            bus.req_stb = '0;
            for (int n = 0; n < 6; n++) step();
        end
        check("cont_count", 64'(obs.size()), 64'd4);
        if (obs.size() == 4) begin
            check("cont_o0", 64'(obs[0]), 64'd0);
            check("cont_o1", 64'(obs[1]), 64'd1);
            check("cont_o2", 64'(obs[2]), 64'd0);
            check("cont_o3", 64'(obs[3]), 64'd1);
        end

        // Backpressure on slot 1 for 10 cycles.
        bus.out_reg_busy = 1'b1;
        set_req(1, 6'd33, 32'h1234_5678);
        step();
        bus.req_stb = '0;
        for (int n = 0; n < 10; n++) step();
        check("bp_busy1", 64'(bus.req_busy[1]), 64'd1);
        bus.out_reg_busy = 1'b0;
        step();
        check("bp_stb", 64'(bus.out_reg_stb), 64'd1);
        check("bp_data", 64'(bus.out_reg_data), 64'h1234_5678);
        for (int n = 0; n < 3; n++) step();

        // Overflow: second strobe into a full slot is dropped.
        bus.out_reg_busy = 1'b1;
        set_req(1, 6'd7, 32'h0000_1111);
        step();
        set_req(1, 6'd8, 32'h0000_2222);
        step();
        bus.req_stb = '0;
        step();
        check("ovf_set", 64'(bus.overflow[1]), 64'd1);
        bus.out_reg_busy = 1'b0;
        step();
        check("ovf_data", 64'(bus.out_reg_data), 64'h0000_1111);
        for (int n = 0; n < 4; n++) step();
        bus.overflow_clr[1] = 1'b1;
        step();
        bus.overflow_clr = '0;
        check("ovf_clr", 64'(bus.overflow[1]), 64'd0);

        // Async reset while strobing, with a slot still full.
        set_req(0, 6'd3, 32'hCAFE_0000);
        set_req(1, 6'd4, 32'hCAFE_0001);
        step();
        bus.req_stb = '0;
        step();
        check("ar_pre_stb", 64'(bus.out_reg_stb), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_stb", 64'(bus.out_reg_stb), 64'd0);
        check("ar_addr", 64'(bus.out_reg_addr), 64'd0);
        check("ar_data", 64'(bus.out_reg_data), 64'd0);
        check("ar_gid", 64'(bus.grant_id), 64'(N - 1));
        check("ar_busy", 64'(bus.req_busy), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        obs.delete();
        for (int n = 0; n < 6; n++) step();
        check("ar_no_stb", 64'(obs.size()), 64'd0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                bus.req_stb[i] = ($urandom_range(0, 3) == 0);
                bus.req_addr[i*AW +: AW] = AW'($urandom);
                bus.req_data[i*DW +: DW] = $urandom;
                bus.overflow_clr[i] = ($urandom_range(0, 7) == 0);
            end
            bus.out_reg_busy = ($urandom_range(0, 3) == 0);
            step();
        end
        clear_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
